// File: rtl/cci_mpf_shim_rd_throttle_pkg.sv
// cci_mpf_shim_rd_throttle_pkg: shared types and helpers for the c0 read-request throttle
package cci_mpf_shim_rd_throttle_pkg;

    localparam int C0_HDR_WIDTH = 74;

    typedef enum logic [1:0] {RUN, DRAINING, DRAINED} t_rd_throttle_state;

    typedef struct packed {
        logic [C0_HDR_WIDTH-1:0] hdr;
        logic [1:0]              cl_len;
    } t_rd_req;

    // cl_len encodes line count minus one
    function automatic logic [2:0] cl_len_to_lines(input logic [1:0] cl_len);
        return {1'b0, cl_len} + 3'd1;
    endfunction

endpackage

// File: rtl/cci_mpf_rd_throttle_fifo.sv
// cci_mpf_rd_throttle_fifo: show-ahead request FIFO with occupancy count
module cci_mpf_rd_throttle_fifo
    import cci_mpf_shim_rd_throttle_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq,
    input  t_rd_req                      enq_data,
    input  logic                         deq,
    output t_rd_req                      first,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    t_rd_req        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= enq_data;
    end

    // Pointer and occupancy tracking; callers never enq when full or deq when empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    assign first = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/cci_mpf_shim_rd_throttle.sv
// cci_mpf_shim_rd_throttle: c0 read-request line-credit limiter with drain handshake (optional stats: CCI_MPF_RD_THROTTLE_STATS_EN)
module cci_mpf_shim_rd_throttle
    import cci_mpf_shim_rd_throttle_pkg::*;
#(
    parameter int MAX_ACTIVE_LINES = 128,
    parameter int BUF_DEPTH        = 8,
    parameter int ALMFULL_SLACK    = 4,
    parameter int HDR_WIDTH        = C0_HDR_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  afu_c0_req_valid,
    input  logic [HDR_WIDTH-1:0]                  afu_c0_req_hdr,
    input  logic [1:0]                            afu_c0_req_cl_len,
    output logic                                  afu_c0_almost_full,
    output logic                                  fiu_c0_req_valid,
    output logic [HDR_WIDTH-1:0]                  fiu_c0_req_hdr,
    output logic [1:0]                            fiu_c0_req_cl_len,
    input  logic                                  fiu_c0_almost_full,
    input  logic                                  fiu_c0_rsp_line,
    input  logic                                  drain_req,
    output logic                                  drained,
    output logic [$clog2(MAX_ACTIVE_LINES+1)-1:0] active_lines,
    output logic                                  overflow_err,
    output logic [31:0]                           stall_cycles
);

    localparam int AW = $clog2(MAX_ACTIVE_LINES+1);
    localparam int CW = $clog2(BUF_DEPTH+1);

    t_rd_throttle_state state;
    t_rd_throttle_state state_next;
    t_rd_req            enq_data;
    t_rd_req            head;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CW-1:0]      fifo_count;
    logic [2:0]         need;
    logic               credit_ok;
    logic               issue_en;
    logic               issue;
    logic               rsp_dec;

    assign enq_data = '{hdr: C0_HDR_WIDTH'(afu_c0_req_hdr), cl_len: afu_c0_req_cl_len};

    cci_mpf_rd_throttle_fifo #(.DEPTH(BUF_DEPTH)) fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (afu_c0_req_valid && !fifo_full),
        .enq_data (enq_data),
        .deq      (issue),
        .first    (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign need      = cl_len_to_lines(head.cl_len);
    assign credit_ok = ({1'b0, active_lines} + (AW+1)'(need)) <= (AW+1)'(MAX_ACTIVE_LINES);
    assign issue     = issue_en && !fifo_empty && !fiu_c0_almost_full && credit_ok;
    // A return with nothing outstanding is ignored so the counter cannot wrap
    assign rsp_dec   = fiu_c0_rsp_line && (active_lines != '0);

    // State register; drained tracks the state being entered so it is registered yet aligned with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            drained <= 1'b0;
        end else begin
            state   <= state_next;
            drained <= (state_next == DRAINED);
        end
    end

    // Next-state: drop of drain_req always returns to RUN; a new enqueue while drained re-opens draining
    always_comb begin
        state_next = state;
        case (state)
            RUN:      state_next = drain_req ? DRAINING : RUN;
            DRAINING: state_next = !drain_req ? RUN :
                                   (active_lines == '0 && fifo_empty) ? DRAINED : DRAINING;
            DRAINED:  state_next = !drain_req ? RUN : fifo_empty ? DRAINED : DRAINING;
            default:  state_next = RUN;
        endcase
    end

    // FSM output: issue only in RUN
    always_comb begin
        issue_en = (state == RUN);
    end

    // Registered FIU request, AFU flow control, credit counter and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fiu_c0_req_valid   <= 1'b0;
            fiu_c0_req_hdr     <= '0;
            fiu_c0_req_cl_len  <= '0;
            afu_c0_almost_full <= 1'b0;
            active_lines       <= '0;
            overflow_err       <= 1'b0;
        end else begin
            fiu_c0_req_valid <= issue;
            if (issue) begin
                fiu_c0_req_hdr    <= head.hdr[HDR_WIDTH-1:0];
                fiu_c0_req_cl_len <= head.cl_len;
            end
            afu_c0_almost_full <= fifo_count >= CW'(BUF_DEPTH - ALMFULL_SLACK);
            active_lines       <= active_lines + (issue ? AW'(need) : AW'(0)) - AW'(rsp_dec);
            if (afu_c0_req_valid && fifo_full) overflow_err <= 1'b1;
        end
    end

`ifdef CCI_MPF_RD_THROTTLE_STATS_EN
    // Count cycles where only a shortage of line credits holds back the head request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cycles <= '0;
        else if (issue_en && !fifo_empty && !fiu_c0_almost_full && !credit_ok && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
